// File: rtl/teclado_pkg.sv
// -----------------------------------------------------------------------------
// teclado_pkg
// Shared definitions for the 4x4 keypad scanner:
//   - state_t     : scanner states (SCAN / DEBOUNCE / HELD)
//   - COL_0..3    : one-hot column drive patterns, COL_0 drives column 0001
//   - ROW_W       : width of the row sense bus
//   - next_column : rotate one-hot column drive 0001->0010->0100->1000->0001
//   - is_onehot   : true when exactly one row line is active
//   - key_code    : (column, row) -> 4-bit key code. The existing keypad
//                   decoder uses this same function, so both blocks produce
//                   identical codes.
// -----------------------------------------------------------------------------
package teclado_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    localparam int ROW_W = 4;

    localparam logic [3:0] COL_0 = 4'b0001;
    localparam logic [3:0] COL_1 = 4'b0010;
    localparam logic [3:0] COL_2 = 4'b0100;
    localparam logic [3:0] COL_3 = 4'b1000;

    function automatic logic [3:0] next_column(input logic [3:0] col);
        return {col[2:0], col[3]};
    endfunction

    // v & (v-1) clears the lowest set bit; nothing left means at most one bit.
    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [3:0] key_code(input logic [3:0] col,
                                            input logic [3:0] row);
        logic [3:0] code;
        code = 4'h0;
        unique case (col)
            COL_0: begin
                unique case (row)
                    4'b1000: code = 4'hA;
                    4'b0100: code = 4'hB;
                    4'b0010: code = 4'hC;
                    4'b0001: code = 4'hD;
                    default: code = 4'h0;
                endcase
            end
            COL_1: begin
                unique case (row)
                    4'b1000: code = 4'h3;
                    4'b0100: code = 4'h6;
                    4'b0010: code = 4'h9;
                    4'b0001: code = 4'hE;
                    default: code = 4'h0;
                endcase
            end
            COL_2: begin
                unique case (row)
                    4'b1000: code = 4'h2;
                    4'b0100: code = 4'h5;
                    4'b0010: code = 4'h8;
                    4'b0001: code = 4'h0;
                    default: code = 4'h0;
                endcase
            end
            COL_3: begin
                unique case (row)
                    4'b1000: code = 4'h1;
                    4'b0100: code = 4'h4;
                    4'b0010: code = 4'h7;
                    4'b0001: code = 4'hF;
                    default: code = 4'h0;
                endcase
            end
            default: code = 4'h0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/teclado_scanner_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for the asynchronous keypad row lines.
// Ports:
//   i_clk  : destination clock
//   i_rst  : synchronous active-high reset, clears both stages
//   i_d    : asynchronous input bus
//   o_q    : synchronized output (two i_clk cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff
    import teclado_pkg::*;
#(
    parameter int WIDTH = ROW_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // NOTE: clocked state is written with non-blocking assignments so every
    // flop samples the pre-edge value; a blocking write here would collapse
    // the two stages into one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/teclado_scanner.sv
// -----------------------------------------------------------------------------
// teclado_scanner
// Drives a 4x4 keypad with a rotating one-hot column pattern, samples the row
// lines once per column period, debounces a single key and reports its code.
// Ports:
//   i_clk_1       : system clock, all logic on posedge
//   i_rst         : synchronous active-high reset
//   i_filas[3:0]  : raw row sense lines, active-high, asynchronous
//   o_column[3:0] : one-hot column drive
//   o_num[3:0]    : code of the last accepted key
//   o_num_valid   : one-cycle pulse when o_num updates
//   o_key_held    : high while the accepted key remains pressed
// Parameters:
//   SCAN_DIV      : clock cycles per column period (>=2)
//   DEBOUNCE_CNT  : consecutive matching samples to accept press/release (>=1)
// -----------------------------------------------------------------------------
module teclado_scanner
    import teclado_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       i_clk_1,
    input  logic       i_rst,
    input  logic [3:0] i_filas,
    output logic [3:0] o_column,
    output logic [3:0] o_num,
    output logic       o_num_valid,
    output logic       o_key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CNT);

    logic [3:0]       w_fs;
    logic             w_sample;
    logic [3:0]       w_cap_code;

    logic [DIV_W-1:0] r_div;
    state_t           r_state;
    logic [3:0]       r_column;
    logic [3:0]       r_cand_row;
    logic [CNT_W-1:0] r_cnt;        // press matches in DEBOUNCE, zero samples in HELD
    logic [3:0]       r_num;
    logic             r_num_valid;
    logic             r_key_held;

    state_t           w_state_nxt;
    logic [3:0]       w_column_nxt;
    logic [3:0]       w_cand_row_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_num_nxt;
    logic             w_num_valid_nxt;
    logic             w_key_held_nxt;

    sync_2ff #(.WIDTH(ROW_W)) u_sync (
        .i_clk (i_clk_1),
        .i_rst (i_rst),
        .i_d   (i_filas),
        .o_q   (w_fs)
    );

    assign w_sample = (r_div == DIV_LAST);

    // The column is frozen while a key is tracked, so the code of the current
    // row sample is valid both at first capture and at final acceptance.
    assign w_cap_code = key_code(r_column, w_fs);

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt     = r_state;
        w_column_nxt    = r_column;
        w_cand_row_nxt  = r_cand_row;
        w_cnt_nxt       = r_cnt;
        w_num_nxt       = r_num;
        w_num_valid_nxt = 1'b0;
        w_key_held_nxt  = r_key_held;

        if (w_sample) begin
            unique case (r_state)
                ST_SCAN: begin
                    if (is_onehot(w_fs)) begin
                        w_cand_row_nxt = w_fs;
                        w_cnt_nxt      = CNT_W'(1);
                        if (DEBOUNCE_CNT == 1) begin
                            w_num_nxt       = w_cap_code;
                            w_num_valid_nxt = 1'b1;
                            w_key_held_nxt  = 1'b1;
                            w_cnt_nxt       = '0;
                            w_state_nxt     = ST_HELD;
                        end else begin
                            w_state_nxt = ST_DEBOUNCE;
                        end
                    end else begin
                        // Idle or ghosted (several rows): keep scanning.
                        w_column_nxt = next_column(r_column);
                    end
                end

                ST_DEBOUNCE: begin
                    if (w_fs == r_cand_row) begin
                        if (r_cnt + CNT_W'(1) == CNT_DONE) begin
                            w_num_nxt       = w_cap_code;
                            w_num_valid_nxt = 1'b1;
                            w_key_held_nxt  = 1'b1;
                            w_cnt_nxt       = '0;
                            w_state_nxt     = ST_HELD;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_cnt_nxt    = '0;
                        w_column_nxt = next_column(r_column);
                        w_state_nxt  = ST_SCAN;
                    end
                end

                ST_HELD: begin
                    // Any activity on the frozen column, including a second
                    // key, restarts the release count.
                    if (w_fs == 4'd0) begin
                        if (r_cnt + CNT_W'(1) == CNT_DONE) begin
                            w_key_held_nxt = 1'b0;
                            w_cnt_nxt      = '0;
                            w_column_nxt   = next_column(r_column);
                            w_state_nxt    = ST_SCAN;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end

                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk_1) begin
        if (i_rst) begin
            r_div       <= '0;
            r_state     <= ST_SCAN;
            r_column    <= COL_0;
            r_cand_row  <= '0;
            r_cnt       <= '0;
            r_num       <= '0;
            r_num_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_div       <= w_sample ? '0 : r_div + DIV_W'(1);
            r_state     <= w_state_nxt;
            r_column    <= w_column_nxt;
            r_cand_row  <= w_cand_row_nxt;
            r_cnt       <= w_cnt_nxt;
            r_num       <= w_num_nxt;
            r_num_valid <= w_num_valid_nxt;
            r_key_held  <= w_key_held_nxt;
        end
    end

    assign o_column    = r_column;
    assign o_num       = r_num;
    assign o_num_valid = r_num_valid;
    assign o_key_held  = r_key_held;

endmodule

// File: tb/tb_teclado_scanner.sv
// -----------------------------------------------------------------------------
// tb_teclado_scanner
// Keypad model drives the row lines from a 4x4 matrix of pressed keys and the
// scanner's column drive. A sample-level reference model predicts accepted
// keys (pushed into a scoreboard queue) plus column/num/key_held after every
// sample point; a monitor pops the queue on every num_valid strobe.
// -----------------------------------------------------------------------------
module tb_teclado_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    // CODE_TBL[column bit][row bit]: column bit 0 is drive 0001, row bit 3 is 1000.
    localparam logic [3:0] CODE_TBL [4][4] = '{
        '{4'hD, 4'hC, 4'hB, 4'hA},
        '{4'hE, 4'h9, 4'h6, 4'h3},
        '{4'h0, 4'h8, 4'h5, 4'h2},
        '{4'hF, 4'h7, 4'h4, 4'h1}
    };

    logic       clk_1 = 1'b0;
    logic       rst   = 1'b1;
    logic [3:0] filas;
    logic [3:0] column;
    logic [3:0] num;
    logic       num_valid;
    logic       key_held;

    teclado_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
        .i_clk_1     (clk_1),
        .i_rst       (rst),
        .i_filas     (filas),
        .o_column    (column),
        .o_num       (num),
        .o_num_valid (num_valid),
        .o_key_held  (key_held)
    );

    always #5 clk_1 = ~clk_1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- keypad matrix ----------------
    bit pressed [4][4];

    always_comb begin
        filas = 4'b0000;
        for (int c = 0; c < 4; c++)
            if (column[c])
                for (int r = 0; r < 4; r++)
                    if (pressed[c][r]) filas[r] = 1'b1;
    end

    task automatic press_code(input int code);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (CODE_TBL[c][r] == 4'(code)) pressed[c][r] = 1'b1;
    endtask

    task automatic release_all();
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                pressed[c][r] = 1'b0;
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_SCAN, M_CONFIRM, M_HOLD} mode_e;

    mode_e      m_mode    = M_SCAN;
    int         m_col     = 0;
    int         m_cand_r  = 0;
    int         m_streak  = 0;
    logic [3:0] m_num     = 4'h0;
    bit         m_held    = 1'b0;
    int         cyc       = 0;
    int         n_samples = 0;
    logic [3:0] exp_q [$];
    logic [3:0] rows;
    logic [3:0] mon_exp;

    always @(posedge clk_1) begin
        if (rst) begin
            m_mode   = M_SCAN;
            m_col    = 0;
            m_streak = 0;
            m_num    = 4'h0;
            m_held   = 1'b0;
            cyc      = 0;
        end else begin
            cyc++;
            if (cyc % SCAN_DIV == 0) begin
                rows = 4'b0000;
                for (int r = 0; r < 4; r++)
                    if (pressed[m_col][r]) rows[r] = 1'b1;
                case (m_mode)
                    M_SCAN: begin
                        if ($countones(rows) == 1) begin
                            for (int r = 0; r < 4; r++)
                                if (rows[r]) m_cand_r = r;
                            m_streak = 1;
                            m_mode   = M_CONFIRM;
                        end else begin
                            m_col = (m_col + 1) % 4;
                        end
                    end
                    M_CONFIRM: begin
                        if (rows == 4'(1 << m_cand_r)) m_streak++;
                        else begin
                            m_mode = M_SCAN;
                            m_col  = (m_col + 1) % 4;
                        end
                    end
                    default: begin
                        if (rows == 4'b0000) m_streak++;
                        else m_streak = 0;
                        if (m_streak == DEB) begin
                            m_held = 1'b0;
                            m_mode = M_SCAN;
                            m_col  = (m_col + 1) % 4;
                        end
                    end
                endcase
                if (m_mode == M_CONFIRM && m_streak == DEB) begin
                    m_num = CODE_TBL[m_col][m_cand_r];
                    exp_q.push_back(m_num);
                    m_held   = 1'b1;
                    m_mode   = M_HOLD;
                    m_streak = 0;
                end
                n_samples++;
                #1;
                check("column after sample", {28'd0, column}, {28'd0, 4'(1 << m_col)});
                check("key_held after sample", {31'd0, key_held}, {31'd0, m_held});
                check("num after sample", {28'd0, num}, {28'd0, m_num});
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk_1) begin
        if (num_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL spurious num_valid: got strobe with num=%0h, expected no strobe (t=%0t)",
                         num, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("num at num_valid", {28'd0, num}, {28'd0, mon_exp});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_samples(input int n);
        int target;
        int guard;
        target = n_samples + n;
        guard  = 0;
        while (n_samples < target && guard < 10000) begin
            @(negedge clk_1);
            guard++;
        end
    endtask

    task automatic wait_mode(input mode_e want, input int max_s);
        int k;
        k = 0;
        while (m_mode != want && k < max_s) begin
            wait_samples(1);
            k++;
        end
    endtask

    task automatic do_reset();
        release_all();
        rst = 1'b1;
        @(negedge clk_1);
        check("reset column", {28'd0, column}, 32'h1);
        check("reset num", {28'd0, num}, 32'h0);
        check("reset num_valid", {31'd0, num_valid}, 32'h0);
        check("reset key_held", {31'd0, key_held}, 32'h0);
        @(negedge clk_1);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        do_reset();

        // Idle rotation with no keys.
        wait_samples(6);

        // Clean press and release of "5".
        press_code(5);
        wait_mode(M_HOLD, 12);
        wait_samples(3);
        release_all();
        wait_mode(M_SCAN, 8);
        wait_samples(2);

        // Bounce of "9": seen on one sample only.
        press_code(9);
        wait_mode(M_CONFIRM, 8);
        release_all();
        wait_samples(4);

        // Ghost: A and B together put 1100 on column 0001.
        press_code(4'hA);
        press_code(4'hB);
        wait_samples(12);
        release_all();
        wait_samples(2);

        // Long hold of "F" with one chattering zero sample.
        press_code(4'hF);
        wait_mode(M_HOLD, 12);
        wait_samples(10);
        release_all();
        wait_samples(1);
        press_code(4'hF);
        wait_samples(10);
        release_all();
        wait_mode(M_SCAN, 8);

        // Reset while debouncing "2".
        press_code(2);
        wait_mode(M_CONFIRM, 8);
        do_reset();
        wait_samples(2);

        // Reset while holding "1".
        press_code(1);
        wait_mode(M_HOLD, 12);
        wait_samples(2);
        do_reset();
        wait_samples(2);

        // Press "A" after reset.
        press_code(4'hA);
        wait_mode(M_HOLD, 12);
        release_all();
        wait_mode(M_SCAN, 8);

        // Randomized presses, occasional ghosts and second keys while held.
        for (int it = 0; it < 40; it++) begin
            int pick;
            pick = $urandom_range(0, 9);
            if (pick < 7) begin
                press_code($urandom_range(0, 15));
            end else if (pick < 9) begin
                press_code($urandom_range(0, 15));
                press_code($urandom_range(0, 15));
            end
            wait_samples($urandom_range(1, 14));
            if ($urandom_range(0, 3) == 0) begin
                press_code($urandom_range(0, 15));
                wait_samples($urandom_range(1, 6));
            end
            release_all();
            wait_samples($urandom_range(1, 10));
        end

        release_all();
        wait_samples(12);
        check("scoreboard drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
